// File: rtl/regbank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter: FSM states and parameter defaults.
package regbank_arbiter_pkg;

    localparam int DEF_M          = 16;
    localparam int DEF_N          = 5;
    localparam int DEF_STARVE_MAX = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        RD     = 2'd2,
        RD_CAP = 2'd3
    } state_t;

endpackage

// File: rtl/regbank_arbiter_rr.sv
// Two-way round-robin arbiter: registered last-grant pointer, combinational grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    // 1 means requester 1 was served last, so requester 0 wins a tie
    logic r_last;

    // Grant the sole requester, or on a tie the one not served last
    always_comb begin
        o_gnt = '0;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
            default: o_gnt = '0;
        endcase
    end

    // Remember which requester was served once the grant is actually taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Arbitrates two write ports and one dual-address read port onto an external register bank.
module regbank_arbiter
    import regbank_arbiter_pkg::*;
#(
    parameter int M          = DEF_M,
    parameter int N          = DEF_N,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr0_valid,
    input  logic [N-1:0] wr0_addr,
    input  logic [M:0]   wr0_data,
    output logic         wr0_ready,
    input  logic         wr1_valid,
    input  logic [N-1:0] wr1_addr,
    input  logic [M:0]   wr1_data,
    output logic         wr1_ready,
    input  logic         rd_req,
    input  logic [N-1:0] rd_addr_1,
    input  logic [N-1:0] rd_addr_2,
    output logic         rd_ack,
    output logic         rd_valid,
    output logic [M:0]   rd_data_1,
    output logic [M:0]   rd_data_2,
    output logic         bank_write_reg,
    output logic         bank_read_reg,
    output logic [N-1:0] bank_end_write,
    output logic [M:0]   bank_write_data,
    output logic [N-1:0] bank_addr_1,
    output logic [N-1:0] bank_addr_2,
    input  logic [M:0]   bank_data_1,
    input  logic [M:0]   bank_data_2
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [SW-1:0]  r_starve;
    logic           r_bank_write;
    logic           r_bank_read;
    logic           r_rd_valid;
    logic [N-1:0]   r_end_write;
    logic [M:0]     r_write_data;
    logic [N-1:0]   r_addr_1;
    logic [N-1:0]   r_addr_2;
    logic [M:0]     r_rd_data_1;
    logic [M:0]     r_rd_data_2;

    logic [1:0]     w_rr_gnt;
    logic           w_wr_grant;
    logic           w_any_wr;
    logic           w_raw0;
    logic           w_raw1;
    logic           w_raw;
    logic           w_rd_win;

    rr_arb2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_req    ({wr1_valid, wr0_valid}),
        .i_accept (w_wr_grant),
        .o_gnt    (w_rr_gnt)
    );

    assign w_any_wr = wr0_valid | wr1_valid;
    assign w_raw0   = wr0_valid && ((wr0_addr == rd_addr_1) || (wr0_addr == rd_addr_2));
    assign w_raw1   = wr1_valid && ((wr1_addr == rd_addr_1) || (wr1_addr == rd_addr_2));
    assign w_raw    = rd_req && (w_raw0 || w_raw1);
    // A pending RAW hazard always defers the read, even with the counter saturated
    assign w_rd_win = rd_req && !w_raw && ((r_starve == STARVE_TOP) || !w_any_wr);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and combinational grants; grants only from IDLE and never during reset
    always_comb begin
        w_state_nxt = r_state;
        wr0_ready   = 1'b0;
        wr1_ready   = 1'b0;
        rd_ack      = 1'b0;
        w_wr_grant  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst) begin
                    if (w_rd_win) begin
                        rd_ack      = 1'b1;
                        w_state_nxt = RD;
                    end else if (w_any_wr) begin
                        w_wr_grant  = 1'b1;
                        wr0_ready   = w_rr_gnt[0];
                        wr1_ready   = w_rr_gnt[1];
                        w_state_nxt = WR;
                    end
                end
            end
            WR:      w_state_nxt = IDLE;
            RD:      w_state_nxt = RD_CAP;
            RD_CAP:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bank strobes, captured addresses/data, read results and starvation count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_write <= 1'b0;
            r_bank_read  <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_end_write  <= '0;
            r_write_data <= '0;
            r_addr_1     <= '0;
            r_addr_2     <= '0;
            r_rd_data_1  <= '0;
            r_rd_data_2  <= '0;
            r_starve     <= '0;
        end else begin
            r_bank_write <= w_wr_grant;
            r_bank_read  <= rd_ack;
            r_rd_valid   <= (r_state == RD_CAP);
            if (w_wr_grant) begin
                r_end_write  <= w_rr_gnt[1] ? wr1_addr : wr0_addr;
                r_write_data <= w_rr_gnt[1] ? wr1_data : wr0_data;
            end
            if (rd_ack) begin
                r_addr_1 <= rd_addr_1;
                r_addr_2 <= rd_addr_2;
            end
            if (r_state == RD_CAP) begin
                r_rd_data_1 <= bank_data_1;
                r_rd_data_2 <= bank_data_2;
            end
            if (!rd_req || rd_ack) begin
                r_starve <= '0;
            end else if (w_wr_grant && (r_starve != STARVE_TOP)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    assign bank_write_reg  = r_bank_write;
    assign bank_read_reg   = r_bank_read;
    assign bank_end_write  = r_end_write;
    assign bank_write_data = r_write_data;
    assign bank_addr_1     = r_addr_1;
    assign bank_addr_2     = r_addr_2;
    assign rd_valid        = r_rd_valid;
    assign rd_data_1       = r_rd_data_1;
    assign rd_data_2       = r_rd_data_2;

endmodule
